// File: rtl/reg_encoder.sv
// reg_encoder: one-hot register-select encoder feeding a 2-entry FIFO, with multi-hot error tracking.
module reg_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [13:0]      in_onehot,
    output logic             in_ready,
    output logic             out_valid,
    output logic [3:0]       out_addr,
    output logic             out_err,
    input  logic             out_ready,
    output logic             err_sticky,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state_q, state_d;
    logic [4:0] head_q, head_d, tail_q, tail_d;
    logic [4:0] enc;
    logic push, pop;
    logic sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // entries are {addr, err}; bit13 maps to 1 and bit0 to 14
    always_comb begin
        enc = 5'b0;
        for (int i = 0; i < 14; i++)
            if (in_onehot[i]) enc = {4'(14 - i), 1'b0};
        if ($countones(in_onehot) > 1) enc = 5'b11111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            tail_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = push ? ONE : EMPTY;
            ONE:     state_d = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
            FULL:    state_d = pop ? ONE : FULL;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        in_ready   = state_q != FULL;
        out_valid  = state_q != EMPTY;
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        {out_addr, out_err} = head_q;
        err_sticky = sticky_q;
        err_cnt    = cnt_q;
    end

    // head is zeroed when the FIFO drains so an empty FIFO reads NONE
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop) head_d = (state_q == FULL) ? tail_q : push ? enc : 5'b0;
        else if (push && state_q == EMPTY) head_d = enc;
        if (push && !pop && state_q == ONE) tail_d = enc;
        sticky_d = (push && enc[0]) || (sticky_q && !err_clr);
        cnt_d    = (push && enc[0] && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
endmodule

// File: tb/tb_reg_encoder.sv
// tb_reg_encoder: directed and random stimulus checked against a queue-based reference model.
module tb_reg_encoder;
    logic clk = 0, rst, in_valid, out_ready, err_clr;
    logic [13:0] in_onehot;
    logic in_ready, out_valid, out_err, in_ready2, out_valid2, out_err2, sticky, sticky2;
    logic [3:0] out_addr, out_addr2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
    int vectors = 0, miscompares = 0;
    logic [4:0] q[$];
    bit m_st;
    int m_cnt;

    always #5 clk = ~clk;

    reg_encoder dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_onehot(in_onehot),
        .in_ready(in_ready), .out_valid(out_valid), .out_addr(out_addr), .out_err(out_err),
        .out_ready(out_ready), .err_sticky(sticky), .err_clr(err_clr), .err_cnt(err_cnt));

    reg_encoder #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_onehot(in_onehot),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_addr(out_addr2), .out_err(out_err2),
        .out_ready(out_ready), .err_sticky(sticky2), .err_clr(err_clr), .err_cnt(err_cnt2));

    function automatic logic [4:0] enc_model(input logic [13:0] w);
        int n = 0, idx = 0;
        for (int i = 0; i < 14; i++) if (w[i]) begin n++; idx = i; end
        return n == 0 ? 5'b0 : n > 1 ? 5'b11111 : {4'(14 - idx), 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit push, pop;
        logic [4:0] e, h;
        @(posedge clk);
        e = enc_model(in_onehot);
        push = in_valid && q.size() < 2;
        pop = out_ready && q.size() > 0;
        if (rst) begin
            q.delete(); m_st = 0; m_cnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            m_st = (push && e[0]) || (m_st && !err_clr);
            if (push && e[0]) m_cnt++;
        end
        #1;
        h = q.size() > 0 ? q[0] : 5'b0;
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_addr", out_addr, h[4:1]);
        chk("out_err", out_err, h[0]);
        chk("in_ready", in_ready, q.size() < 2);
        chk("err_sticky", sticky, m_st);
        chk("err_cnt", err_cnt, m_cnt > 255 ? 255 : m_cnt);
        chk("err_cnt_w2", err_cnt2, m_cnt > 3 ? 3 : m_cnt);
        chk("out_addr_w2", out_addr2, h[4:1]);
    endtask

    task automatic drv(input logic v, input logic [13:0] oh, input logic ordy,
                       input logic clr, input logic r);
        in_valid = v; in_onehot = oh; out_ready = ordy; err_clr = clr; rst = r;
        step();
    endtask

    initial begin
        drv(0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 1);
        drv(1, 14'h2000, 1, 0, 0);
        drv(0, 0, 1, 0, 0);
        drv(1, 14'h0001, 0, 0, 0);
        drv(1, 14'h0010, 0, 0, 0);
        drv(1, 14'h0008, 0, 0, 0);
        drv(0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0);
        drv(0, 0, 1, 0, 0);
        drv(1, 14'h0003, 1, 0, 0);
        drv(1, 14'h0003, 1, 1, 0);
        drv(0, 0, 1, 1, 0);
        drv(1, 14'h0000, 1, 0, 0);
        for (int i = 0; i < 5; i++) drv(1, 14'h0c00, 1, 0, 0);
        drv(1, 14'h0100, 0, 0, 0);
        drv(1, 14'h0300, 0, 0, 0);
        drv(1, 14'h0040, 1, 1, 1);
        drv(0, 0, 1, 0, 0);
        for (int i = 0; i < 400; i++) begin
            int k = $urandom_range(0, 3);
            logic [13:0] w;
            w = k == 0 ? 14'h0 : k == 3 ? 14'($urandom) : 14'h1 << $urandom_range(0, 13);
            drv($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_encoder.md
REG_ENCODER -- requirements
Module: reg_encoder

Interface
REQ-001 Parameter CNT_W, default 8, width of the saturating error counter.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer presents a register-select word.
REQ-005 in_onehot  input  14  register-select word; bit13=H, bit12=W, bit11=K, bit10=COUNT, bit9=X, bit8=J, bit7=L, bit6=CENTERP, bit5=T, bit4=AC, bit3=PC, bit2=MDR, bit1=MAR, bit0=IR.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out_valid  output  1  encoded entry available at head of buffer.
REQ-008 out_addr  output  4  encoded register address of head entry.
REQ-009 out_err  output  1  head entry was multi-hot.
REQ-010 out_ready  input  1  consumer accepts head entry.
REQ-011 err_sticky  output  1  latched flag: at least one multi-hot word accepted since last clear.
REQ-012 err_clr  input  1  clears err_sticky.
REQ-013 err_cnt  output  CNT_W  count of accepted multi-hot words, saturating.

Function
REQ-014 Encoding SHALL be: bit13->4'b0001, bit12->4'b0010, bit11->4'b0011, bit10->4'b0100, bit9->4'b0101, bit8->4'b0110, bit7->4'b0111, bit6->4'b1000, bit5->4'b1001, bit4->4'b1010, bit3->4'b1011, bit2->4'b1100, bit1->4'b1101, bit0->4'b1110.
REQ-015 All-zero in_onehot SHALL encode to 4'b0000 with err=0 (NONE, legal).
REQ-016 Two or more bits set SHALL encode to 4'b1111 with err=1.
REQ-017 Encoded {addr, err} pairs SHALL be held in a 2-entry FIFO; occupancy states EMPTY, ONE, FULL.
REQ-018 Push SHALL occur when in_valid && in_ready; pop when out_valid && out_ready.
REQ-019 in_ready SHALL equal (state != FULL) and SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL equal (state != EMPTY); out_addr/out_err SHALL be driven from registers only.
REQ-021 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; all others hold.
REQ-022 Latency: word pushed at edge N SHALL appear on out_addr with out_valid=1 immediately after edge N when the FIFO was EMPTY.
REQ-023 Order SHALL be preserved; no entry is dropped or duplicated.
REQ-024 Head entry SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 in_onehot SHALL be ignored when in_valid=0 or in_ready=0 (no count, no sticky update).
REQ-026 err_cnt SHALL increment by 1 on each push with err=1 and saturate at 2^CNT_W-1.
REQ-027 err_sticky SHALL set on push with err=1; cleared by err_clr; set SHALL win when both occur in the same cycle.
REQ-028 When EMPTY, out_addr SHALL read 4'b0000 and out_err 0.

Reset
REQ-029 On rst=1 at a clock edge: state=EMPTY, out_valid=0, out_addr=0, out_err=0, in_ready=1 after the edge, err_sticky=0, err_cnt=0.
REQ-030 Reset mid-transfer SHALL discard all buffered entries; rst SHALL take priority over push, pop and err_clr in the same cycle.

Verification
REQ-031 Single push in_onehot=14'h2000 with out_ready=1 -> next cycle out_valid=1, out_addr=4'b0001, out_err=0; following cycle out_valid=0.
REQ-032 out_ready=0, push 14'h0001, 14'h0010, attempt 14'h0008 -> in_ready=0 after second push; third word not taken; release out_ready -> outputs 4'b1110 then 4'b1010.
REQ-033 Push 14'h0003 -> out_addr=4'b1111, out_err=1, err_sticky=1, err_cnt=1; assert err_clr with another 14'h0003 push -> err_sticky stays 1, err_cnt=2.
REQ-034 Push 14'h0000 -> out_addr=4'b0000, out_err=0, err_cnt unchanged.
REQ-035 CNT_W=2, push 5 multi-hot words -> err_cnt saturates at 3.
REQ-036 FULL FIFO, assert rst for one cycle -> out_valid=0, in_ready=1, err_cnt=0, err_sticky=0; prior entries never emerge.
